// File: rtl/parking_gate_arbiter.sv
// Shared barrier-gate controller: arbitrates entry/exit lanes, checks the entry
// pass code, sequences open/passing/close and tracks lot occupancy.
module parking_gate_arbiter #(
    parameter int         CAPACITY    = 8,
    parameter int         CNT_W       = 4,
    parameter logic [1:0] PASS_CODE   = 2'b01,
    parameter int         OPEN_CYCLES = 16,
    parameter int         DENY_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ent_req,
    input  logic             exit_req,
    input  logic [1:0]       pass_in,
    input  logic             gate_sensor,
    output logic             gate_open,
    output logic             dir,
    output logic             ent_ack,
    output logic             exit_ack,
    output logic             deny,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             GREEN_LED,
    output logic             RED_LED
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_OPEN,
        S_PASSING,
        S_DENY
    } state_e;

    localparam logic [CNT_W-1:0] CAP       = CNT_W'(CAPACITY);
    localparam logic [7:0]       OPEN_LAST = 8'(OPEN_CYCLES - 1);
    localparam logic [7:0]       DENY_LAST = 8'(DENY_CYCLES - 1);

    state_e           state_q, state_d;
    logic [7:0]       timer_q, timer_d;
    logic [CNT_W-1:0] occupancy_q, occupancy_d;
    logic             last_dir_q, last_dir_d;
    logic             dir_q, dir_d;
    logic [1:0]       code_q, code_d;
    logic             ent_ack_q, ent_ack_d;
    logic             exit_ack_q, exit_ack_d;

    logic is_full, is_empty, exit_ok, grant_exit, grant_ent;

    assign is_full  = (occupancy_q == CAP);
    assign is_empty = (occupancy_q == '0);
    // An exit from an empty lot is never eligible, so it cannot steal a tie.
    assign exit_ok    = exit_req && !is_empty;
    assign grant_exit = exit_ok && (!ent_req || !last_dir_q);
    assign grant_ent  = ent_req && !grant_exit;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            occupancy_q <= '0;
            last_dir_q  <= 1'b1;
            dir_q       <= 1'b0;
            code_q      <= '0;
            ent_ack_q   <= 1'b0;
            exit_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            occupancy_q <= occupancy_d;
            last_dir_q  <= last_dir_d;
            dir_q       <= dir_d;
            code_q      <= code_d;
            ent_ack_q   <= ent_ack_d;
            exit_ack_q  <= exit_ack_d;
        end
    end

    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        occupancy_d = occupancy_q;
        last_dir_d  = last_dir_q;
        dir_d       = dir_q;
        code_d      = code_q;
        ent_ack_d   = 1'b0;
        exit_ack_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_ent) begin
                    last_dir_d = 1'b0;
                    dir_d      = 1'b0;
                    ent_ack_d  = 1'b1;
                    timer_d    = '0;
                    if (is_full) begin
                        state_d = S_DENY;
                    end else begin
                        code_d  = pass_in;
                        state_d = S_CHECK;
                    end
                end else if (grant_exit) begin
                    last_dir_d = 1'b1;
                    dir_d      = 1'b1;
                    exit_ack_d = 1'b1;
                    timer_d    = '0;
                    state_d    = S_OPEN;
                end
            end
            S_CHECK: begin
                timer_d = '0;
                state_d = (code_q == PASS_CODE) ? S_OPEN : S_DENY;
            end
            S_OPEN: begin
                if (gate_sensor) begin
                    state_d = S_PASSING;
                end else if (timer_q == OPEN_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_PASSING: begin
                // No timeout here: the gate must never close on a car.
                if (!gate_sensor) begin
                    state_d = S_IDLE;
                    if (!dir_q && !is_full) begin
                        occupancy_d = occupancy_q + CNT_W'(1);
                    end else if (dir_q && !is_empty) begin
                        occupancy_d = occupancy_q - CNT_W'(1);
                    end
                end
            end
            S_DENY: begin
                if (timer_q == DENY_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gate_open = (state_q == S_OPEN) || (state_q == S_PASSING);
        GREEN_LED = gate_open;
        deny      = (state_q == S_DENY);
        RED_LED   = (state_q == S_DENY) || ((state_q == S_IDLE) && is_full);
        dir       = dir_q;
        ent_ack   = ent_ack_q;
        exit_ack  = exit_ack_q;
        occupancy = occupancy_q;
        full      = is_full;
        empty     = is_empty;
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: directed scenarios plus
// randomized lane traffic against a transaction-level reference model.
module tb_parking_gate_arbiter;

    localparam int         CAPACITY    = 8;
    localparam int         CNT_W       = 4;
    localparam logic [1:0] PASS_CODE   = 2'b01;
    localparam int         OPEN_CYCLES = 16;
    localparam int         DENY_CYCLES = 8;

    typedef enum int {PH_IDLE, PH_CHECK, PH_GATE, PH_DENY} phase_t;
    typedef enum int {G_ENTRY, G_EXIT, G_NONE} grant_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             ent_req, exit_req, gate_sensor;
    logic [1:0]       pass_in;
    logic             gate_open, dir, ent_ack, exit_ack, deny, full, empty;
    logic             GREEN_LED, RED_LED;
    logic [CNT_W-1:0] occupancy;

    int occ_m;
    bit last_dir_m;
    int vectors;
    int miscompares;

    parking_gate_arbiter #(
        .CAPACITY(CAPACITY), .CNT_W(CNT_W), .PASS_CODE(PASS_CODE),
        .OPEN_CYCLES(OPEN_CYCLES), .DENY_CYCLES(DENY_CYCLES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ent_req(ent_req), .exit_req(exit_req),
        .pass_in(pass_in), .gate_sensor(gate_sensor), .gate_open(gate_open),
        .dir(dir), .ent_ack(ent_ack), .exit_ack(exit_ack), .deny(deny),
        .occupancy(occupancy), .full(full), .empty(empty),
        .GREEN_LED(GREEN_LED), .RED_LED(RED_LED)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs follow directly from the lane-visible phase and model count.
    task automatic expect_outs(input string tag, input phase_t ph, input bit e_ack,
                               input bit x_ack, input int exp_dir);
        check($sformatf("%s.gate_open", tag), gate_open, ph == PH_GATE);
        check($sformatf("%s.green", tag), GREEN_LED, ph == PH_GATE);
        check($sformatf("%s.deny", tag), deny, ph == PH_DENY);
        check($sformatf("%s.red", tag), RED_LED,
              (ph == PH_DENY) || (ph == PH_IDLE && occ_m == CAPACITY));
        check($sformatf("%s.ent_ack", tag), ent_ack, e_ack);
        check($sformatf("%s.exit_ack", tag), exit_ack, x_ack);
        check($sformatf("%s.occupancy", tag), occupancy, occ_m);
        check($sformatf("%s.full", tag), full, occ_m == CAPACITY);
        check($sformatf("%s.empty", tag), empty, occ_m == 0);
        if (exp_dir >= 0) check($sformatf("%s.dir", tag), dir, exp_dir);
    endtask

    function automatic grant_t pick(input bit e, input bit x);
        bit x_ok = x && (occ_m != 0);
        if (e && x_ok) return last_dir_m ? G_ENTRY : G_EXIT;
        if (e) return G_ENTRY;
        if (x_ok) return G_EXIT;
        return G_NONE;
    endfunction

    // Called on the negedge of the first DENY cycle; returns on the IDLE negedge.
    task automatic deny_hold(input string tag, input bit first_ack);
        for (int i = 0; i < DENY_CYCLES; i++) begin
            if (i > 0) @(negedge clk);
            expect_outs($sformatf("%s.deny%0d", tag, i), PH_DENY, first_ack && i == 0, 1'b0, -1);
        end
        gate_sensor = 1'b0;
        @(negedge clk);
        expect_outs($sformatf("%s.after_deny", tag), PH_IDLE, 1'b0, 1'b0, -1);
    endtask

    // Called on the negedge of the first OPEN cycle; len==0 means no car arrives.
    task automatic gate_phase(input string tag, input bit d, input int len, input bit first_x_ack);
        gate_sensor = 1'b0;
        if (len == 0) begin
            for (int i = 0; i < OPEN_CYCLES; i++) begin
                if (i > 0) @(negedge clk);
                expect_outs($sformatf("%s.open%0d", tag, i), PH_GATE, 1'b0, first_x_ack && i == 0, d);
            end
        end else begin
            int w = $urandom_range(0, 3);
            for (int i = 0; i <= w; i++) begin
                if (i > 0) @(negedge clk);
                expect_outs($sformatf("%s.open%0d", tag, i), PH_GATE, 1'b0, first_x_ack && i == 0, d);
            end
            gate_sensor = 1'b1;
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                expect_outs($sformatf("%s.pass%0d", tag, i), PH_GATE, 1'b0, 1'b0, d);
            end
            gate_sensor = 1'b0;
            if (d == 1'b0 && occ_m < CAPACITY) occ_m++;
            else if (d == 1'b1 && occ_m > 0) occ_m--;
        end
        @(negedge clk);
        expect_outs($sformatf("%s.closed", tag), PH_IDLE, 1'b0, 1'b0, -1);
    endtask

    // Requests are already driven; returns on the negedge of the first IDLE cycle.
    task automatic run_txn(input string tag, input grant_t g, input logic [1:0] code, input int len);
        @(negedge clk);
        if (g == G_ENTRY) begin
            last_dir_m = 1'b0;
            if (occ_m == CAPACITY) begin
                ent_req = 1'b0;
                deny_hold({tag, ".full"}, 1'b1);
            end else begin
                expect_outs({tag, ".check"}, PH_CHECK, 1'b1, 1'b0, 0);
                ent_req     = 1'b0;
                pass_in     = 2'($urandom);
                gate_sensor = 1'($urandom);
                @(negedge clk);
                if (code == PASS_CODE) gate_phase(tag, 1'b0, len, 1'b0);
                else deny_hold({tag, ".code"}, 1'b0);
            end
        end else begin
            last_dir_m = 1'b1;
            exit_req   = 1'b0;
            gate_phase(tag, 1'b1, len, 1'b1);
        end
    endtask

    initial begin
        grant_t g;
        bit e, x;
        logic [1:0] code;
        int len;

        vectors = 0; miscompares = 0;
        occ_m = 0; last_dir_m = 1'b1;
        reset_n = 1'b0; ent_req = 1'b0; exit_req = 1'b0;
        pass_in = 2'b00; gate_sensor = 1'b0;

        repeat (2) @(negedge clk);
        expect_outs("reset", PH_IDLE, 1'b0, 1'b0, 0);
        reset_n = 1'b1;
        @(negedge clk);
        expect_outs("post_reset", PH_IDLE, 1'b0, 1'b0, 0);

        ent_req = 1'b1; pass_in = PASS_CODE;
        run_txn("valid_entry", pick(1, 0), PASS_CODE, 3);

        ent_req = 1'b1; pass_in = 2'b10;
        run_txn("wrong_code", pick(1, 0), 2'b10, 2);

        while (occ_m < CAPACITY) begin
            ent_req = 1'b1; pass_in = PASS_CODE;
            run_txn($sformatf("fill%0d", occ_m), pick(1, 0), PASS_CODE, $urandom_range(1, 3));
        end
        check("full_flag", full, 1'b1);
        check("full_red", RED_LED, 1'b1);

        ent_req = 1'b1; pass_in = PASS_CODE;
        run_txn("ninth_entry", pick(1, 0), PASS_CODE, 1);
        check("ninth_occ", occupancy, CAPACITY);

        while (occ_m > 2) begin
            exit_req = 1'b1;
            run_txn($sformatf("drain%0d", occ_m), pick(0, 1), PASS_CODE, 1);
        end

        ent_req = 1'b1; exit_req = 1'b1; pass_in = PASS_CODE;
        for (int r = 0; r < 3; r++) begin
            g = pick(1, 1);
            check($sformatf("tie%0d.order", r), g, (r == 1) ? G_EXIT : G_ENTRY);
            run_txn($sformatf("tie%0d", r), g, PASS_CODE, 2);
            ent_req = 1'b1; exit_req = 1'b1; pass_in = PASS_CODE;
        end
        ent_req = 1'b0; exit_req = 1'b0;
        check("tie_occ", occupancy, 3);

        exit_req = 1'b1;
        run_txn("exit_timeout", pick(0, 1), PASS_CODE, 0);
        check("timeout_occ", occupancy, 3);

        for (int n = 0; n < 40; n++) begin
            e = 1'($urandom); x = 1'($urandom);
            if (!e && !x) e = 1'b1;
            code = ($urandom_range(0, 3) == 0) ? 2'($urandom) : PASS_CODE;
            len  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 4);
            g = pick(e, x);
            ent_req = e; exit_req = x; pass_in = code;
            if (g == G_NONE) begin
                repeat (2) begin
                    @(negedge clk);
                    expect_outs($sformatf("rnd%0d.ignored", n), PH_IDLE, 1'b0, 1'b0, -1);
                end
            end else begin
                run_txn($sformatf("rnd%0d", n), g, code, len);
            end
            ent_req = 1'b0; exit_req = 1'b0;
        end

        ent_req = 1'b1; pass_in = PASS_CODE;
        @(negedge clk);
        ent_req = 1'b0;
        @(negedge clk);
        check("pre_reset_open", gate_open, 1'b1);
        #1 reset_n = 1'b0;
        occ_m = 0; last_dir_m = 1'b1;
        #1;
        check("async_reset.gate_open", gate_open, 1'b0);
        check("async_reset.occupancy", occupancy, 0);
        check("async_reset.empty", empty, 1'b1);
        check("async_reset.green", GREEN_LED, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        expect_outs("after_reset", PH_IDLE, 1'b0, 1'b0, 0);

        exit_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            expect_outs("empty_exit", PH_IDLE, 1'b0, 1'b0, -1);
        end
        ent_req = 1'b1; pass_in = PASS_CODE;
        g = pick(1, 1);
        check("empty_exit.grant", g, G_ENTRY);
        run_txn("entry_vs_empty_exit", g, PASS_CODE, 2);
        ent_req = 1'b0; exit_req = 1'b0;
        @(negedge clk);
        expect_outs("final", PH_IDLE, 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
